// File: rtl/fifo_rd_stream.sv
// Read-domain output stage of the async FIFO: turns rempty/rinc/rdata into an in-order valid/ready stream.
// Latency: 2 rclk from first rinc to m_valid. Backpressure: a 2-entry skid buffer stalls issue when committed words reach 2.
module fifo_rd_stream #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       m_level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             occ;
  logic             inflight;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] second;
  logic             pop;
  logic [2:0]       committed;

  assign pop       = m_valid & m_ready;
  // Words held or already requested after this cycle's pop; m_ready feeds rinc combinationally for full rate.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rinc      = rrst_n & ~rempty & (committed < 3'd2);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ      <= EMPTY;
      inflight <= 1'b0;
      head     <= '0;
      second   <= '0;
      m_valid  <= 1'b0;
    end else begin
      inflight <= rinc;
      case (occ)
        EMPTY: begin
          if (inflight) begin
            occ     <= ONE;
            head    <= rdata;
            m_valid <= 1'b1;
          end
        end
        ONE: begin
          if (inflight && !pop) begin
            occ    <= TWO;
            second <= rdata;
          end else if (!inflight && pop) begin
            occ     <= EMPTY;
            m_valid <= 1'b0;
          end else if (inflight && pop) begin
            head <= rdata;
          end
        end
        TWO: begin
          // The issue rule keeps inflight low here, so only a pop can change state.
          if (pop) begin
            occ  <= ONE;
            head <= second;
          end
        end
        default: begin
          occ     <= EMPTY;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign m_data  = head;
  assign m_level = occ;

  a_no_overfill: assert property (@(posedge rclk) disable iff (!rrst_n) !((occ == TWO) && inflight));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based pointer/RAM model, scoreboard monitor and directed/random phases.
module tb_fifo_rd_stream;
  localparam int DSIZE = 8;

  logic             rclk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             rempty = 1'b1;
  logic             rinc;
  logic [DSIZE-1:0] rdata = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DSIZE-1:0] m_data;
  logic [1:0]       m_level;

  fifo_rd_stream #(.DSIZE(DSIZE)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_level (m_level)
  );

  always #5 rclk = ~rclk;

  logic [DSIZE-1:0] wr_q[$];
  logic [DSIZE-1:0] ram_q[$];
  logic [DSIZE-1:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic put(input logic [DSIZE-1:0] w);
    wr_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  // Pointer logic + registered-read RAM: a word requested in one cycle appears on rdata the next.
  initial begin
    logic rinc_s;
    forever begin
      @(negedge rclk);
      rinc_s = rinc;
      @(posedge rclk);
      #1;
      if (!rrst_n) begin
        ram_q.delete();
        wr_q.delete();
        rdata  = '0;
        rempty = 1'b1;
      end else begin
        if (rinc_s && ram_q.size() > 0) rdata = ram_q.pop_front();
        else rdata = DSIZE'($urandom_range(0, 255));
        while (wr_q.size() > 0) ram_q.push_back(wr_q.pop_front());
        rempty = (ram_q.size() == 0);
      end
    end
  end

  // Monitor: occupancy bookkeeping from the stream rules plus in-order scoreboard.
  initial begin
    int               level_m = 0;
    int               infl_m = 0;
    int               pop_i;
    logic             hold = 1'b0;
    logic [DSIZE-1:0] hold_dat = '0;
    forever begin
      @(negedge rclk or negedge rrst_n);
      if (!rrst_n) begin
        #1;
        check("rst_valid", int'(m_valid), 0);
        check("rst_level", int'(m_level), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_rinc", int'(rinc), 0);
        exp_q.delete();
        level_m = 0;
        infl_m  = 0;
        hold    = 1'b0;
      end else begin
        pop_i = (m_valid && m_ready) ? 1 : 0;
        check("level", int'(m_level), level_m);
        check("valid", int'(m_valid), (level_m != 0) ? 1 : 0);
        if (rinc) begin
          check("rinc_nonempty", int'(rempty), 0);
          check("rinc_room", (level_m + infl_m - pop_i < 2) ? 1 : 0, 1);
        end
        if (hold) begin
          check("hold_valid", int'(m_valid), 1);
          check("hold_data", int'(m_data), int'(hold_dat));
        end
        if (pop_i == 1) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pop: got data 0x%0h, expected no word at %0t", m_data, $time);
          end else begin
            check("data_order", int'(m_data), int'(exp_q.pop_front()));
          end
        end
        hold     = m_valid && !m_ready;
        hold_dat = m_data;
        level_m  = level_m + infl_m - pop_i;
        infl_m   = rinc ? 1 : 0;
      end
    end
  end

  initial begin
    int               rinc_cnt;
    int               pop_cnt;
    int               t_e;
    int               t_v;
    int               first_pop;
    int               last_pop;
    logic             prev_rinc;
    logic             armed;
    logic             found;
    logic [DSIZE-1:0] exp_new;

    // 1: reset, then idle with rempty=1
    repeat (3) step();
    rrst_n = 1'b1;
    rinc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (rinc) rinc_cnt++;
    end
    check("idle_rinc_cnt", rinc_cnt, 0);
    step();

    // 2: four words, consumer always ready
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(8'h11 + 8'(i));
    t_e = -1; t_v = -1; rinc_cnt = 0; pop_cnt = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (t_e < 0 && !rempty) t_e = i;
      if (t_v < 0 && m_valid) t_v = i;
      if (rinc) rinc_cnt++;
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = i;
        last_pop = i;
      end
    end
    check("t2_latency", t_v - t_e, 2);
    check("t2_rinc_cnt", rinc_cnt, 4);
    check("t2_pop_cnt", pop_cnt, 4);
    check("t2_back_to_back", last_pop - first_pop, 3);
    check("t2_drained", exp_q.size(), 0);
    step();

    // 3: five words, consumer stalled, then released
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) put(8'h31 + 8'(i));
    rinc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge rclk);
      if (rinc) rinc_cnt++;
    end
    check("t3_rinc_cnt", rinc_cnt, 2);
    check("t3_level", int'(m_level), 2);
    check("t3_head", int'(m_data), 'h31);
    step();
    m_ready = 1'b1;
    pop_cnt = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge rclk);
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = i;
        last_pop = i;
      end
    end
    check("t3_pop_cnt", pop_cnt, 5);
    check("t3_no_gap", last_pop - first_pop, 4);
    check("t3_drained", exp_q.size(), 0);
    step();

    // 4: toggling ready with eight queued words
    for (int i = 0; i < 8; i++) put(8'h41 + 8'(i));
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    m_ready = 1'b1;
    repeat (10) step();
    check("t4_drained", exp_q.size(), 0);

    // 5: arrival coinciding with a pop in the one-word state
    put(8'h51);
    put(8'h52);
    prev_rinc = 1'b0; armed = 1'b0; found = 1'b0; exp_new = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (armed) begin
        check("t5_level", int'(m_level), 1);
        check("t5_data", int'(m_data), int'(exp_new));
        armed = 1'b0;
        found = 1'b1;
      end
      if (!found && m_level == 2'd1 && prev_rinc && m_valid && m_ready) begin
        armed   = 1'b1;
        exp_new = rdata;
      end
      prev_rinc = rinc;
    end
    check("t5_seen", int'(found), 1);
    step();

    // 6: reset while the buffer is full and a word is still pending in the RAM
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) put(8'h71 + 8'(i));
    repeat (8) step();
    check("t6_pre_level", int'(m_level), 2);
    #1;
    rrst_n = 1'b0;
    #1;
    check("t6_async_valid", int'(m_valid), 0);
    check("t6_async_level", int'(m_level), 0);
    repeat (3) step();
    rrst_n = 1'b1;
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) put(8'h61 + 8'(i));
    pop_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge rclk);
      if (m_valid && m_ready) pop_cnt++;
    end
    check("t6_restart_pops", pop_cnt, 3);
    check("t6_drained", exp_q.size(), 0);
    step();

    // Random traffic and backpressure
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) put(DSIZE'($urandom_range(0, 255)));
      end
      m_ready = (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      step();
    end
    m_ready = 1'b1;
    repeat (600) step();
    check("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
